// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared constants for the MIPS memory stage
// State encodings, control-bundle bit positions and default sizes.
package mem_stage_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam int CTRL_WB_REGWRITE = 1;
  localparam int CTRL_WB_MEMTOREG = 0;

  localparam int CTRL_MEM_BRANCH = 2;
  localparam int CTRL_MEM_WRITE  = 1;
  localparam int CTRL_MEM_READ   = 0;

  localparam int WREG_W = 5;

  localparam int TIMEOUT_CYC_DEFAULT = 64;

endpackage

// File: rtl/memstage_req_fsm.sv
// rtl/memstage_req_fsm.sv - data-memory request FSM with held request registers
// Optional abort timer enabled by MEMSTAGE_TIMEOUT_EN.
module memstage_req_fsm
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32
`ifdef MEMSTAGE_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
`endif
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [1:0]        ctrl_wb_i,
  input  logic [WREG_W-1:0] wreg_i,
  input  logic              mem_ack_i,
  output logic              busy_o,
  output logic              done_o,
`ifdef MEMSTAGE_TIMEOUT_EN
  output logic              timeout_o,
`endif
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [1:0]        ctrl_wb_o,
  output logic [WREG_W-1:0] wreg_o
);

  logic [0:0]        state_q, state_d;
  logic              we_q;
  logic [DATA_W-1:0] addr_q, wdata_q;
  logic [1:0]        ctrl_wb_q;
  logic [WREG_W-1:0] wreg_q;
  logic              abort;

  assign busy_o = (state_q == ST_BUSY);
  assign done_o = busy_o & mem_ack_i;

`ifdef MEMSTAGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // An ack in the final cycle takes precedence over the abort.
  assign timeout_o = busy_o & ~mem_ack_i & (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign abort     = timeout_o;

  always_comb begin
    cnt_d = '0;
    if (busy_o) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_BUSY;
      ST_BUSY: if (mem_ack_i || abort) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ctrl_wb_q <= '0;
      wreg_q    <= '0;
    end else begin
      state_q <= state_d;
      if (start_i && !busy_o) begin
        we_q      <= we_i;
        addr_q    <= addr_i;
        wdata_q   <= wdata_i;
        ctrl_wb_q <= ctrl_wb_i;
        wreg_q    <= wreg_i;
      end
    end
  end

  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign ctrl_wb_o   = ctrl_wb_q;
  assign wreg_o      = wreg_q;

endmodule

// File: rtl/mem_stage_unit.sv
// rtl/mem_stage_unit.sv - MIPS memory stage: branch resolve, load/store, MEM/WB register
// Define MEMSTAGE_TIMEOUT_EN to add the transfer-abort timer and Mem_Err_Out.
module mem_stage_unit
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32
`ifdef MEMSTAGE_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
`endif
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Valid_In,
  input  logic [1:0]        Ctrl_WBIn,
  input  logic [2:0]        Ctrl_MemIn,
  input  logic [DATA_W-1:0] Adder_ResultIn,
  input  logic [DATA_W-1:0] ALU_ResultIn,
  input  logic              ALU_ZeroIn,
  input  logic [DATA_W-1:0] Register2_ReadIn,
  input  logic [WREG_W-1:0] WriteReg_In,
  output logic              Stall_Out,
  output logic              PCSrc_Out,
  output logic [DATA_W-1:0] BranchTarget_Out,
  output logic              Mem_Req,
  output logic              Mem_We,
  output logic [DATA_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_WData,
  input  logic              Mem_Ack,
  input  logic [DATA_W-1:0] Mem_RData,
`ifdef MEMSTAGE_TIMEOUT_EN
  output logic              Mem_Err_Out,
`endif
  output logic              Valid_Out,
  output logic [1:0]        Ctrl_WBOut,
  output logic [DATA_W-1:0] ReadData_Out,
  output logic [DATA_W-1:0] ALU_ResultOut,
  output logic [WREG_W-1:0] WriteReg_Out
);

  logic              busy, done, accept, is_mem, illegal, timeout;
  logic [1:0]        cap_wb, fsm_wb;
  logic [WREG_W-1:0] fsm_wreg;

  logic              valid_q;
  logic [1:0]        ctrl_wb_q;
  logic [DATA_W-1:0] rdata_q, alu_q;
  logic [WREG_W-1:0] wreg_q;

  assign accept  = Valid_In & ~busy;
  assign is_mem  = Ctrl_MemIn[CTRL_MEM_READ] | Ctrl_MemIn[CTRL_MEM_WRITE];
  assign illegal = Ctrl_MemIn[CTRL_MEM_READ] & Ctrl_MemIn[CTRL_MEM_WRITE];
  // Read+write runs as a store and must not write back a register.
  assign cap_wb  = {Ctrl_WBIn[CTRL_WB_REGWRITE] & ~illegal, Ctrl_WBIn[CTRL_WB_MEMTOREG]};

  assign Stall_Out        = busy;
  assign Mem_Req          = busy;
  assign PCSrc_Out        = Valid_In & Ctrl_MemIn[CTRL_MEM_BRANCH] & ALU_ZeroIn & ~busy;
  assign BranchTarget_Out = Adder_ResultIn;

  memstage_req_fsm #(
    .DATA_W(DATA_W)
`ifdef MEMSTAGE_TIMEOUT_EN
    , .TIMEOUT_CYC(TIMEOUT_CYC)
`endif
  ) u_req_fsm (
    .clk_i      (Clk),
    .rst_i      (Rst),
    .start_i    (accept & is_mem),
    .we_i       (Ctrl_MemIn[CTRL_MEM_WRITE]),
    .addr_i     (ALU_ResultIn),
    .wdata_i    (Register2_ReadIn),
    .ctrl_wb_i  (cap_wb),
    .wreg_i     (WriteReg_In),
    .mem_ack_i  (Mem_Ack),
    .busy_o     (busy),
    .done_o     (done),
`ifdef MEMSTAGE_TIMEOUT_EN
    .timeout_o  (timeout),
`endif
    .mem_we_o   (Mem_We),
    .mem_addr_o (Mem_Addr),
    .mem_wdata_o(Mem_WData),
    .ctrl_wb_o  (fsm_wb),
    .wreg_o     (fsm_wreg)
  );

`ifndef MEMSTAGE_TIMEOUT_EN
  assign timeout = 1'b0;
`else
  logic err_q;
  always_ff @(posedge Clk) begin
    if (Rst) err_q <= 1'b0;
    else     err_q <= timeout;
  end
  assign Mem_Err_Out = err_q;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      valid_q   <= 1'b0;
      ctrl_wb_q <= '0;
      rdata_q   <= '0;
      alu_q     <= '0;
      wreg_q    <= '0;
    end else begin
      valid_q <= (accept & ~is_mem) | done | timeout;
      if (accept && !is_mem) begin
        ctrl_wb_q <= Ctrl_WBIn;
        rdata_q   <= '0;
        alu_q     <= ALU_ResultIn;
        wreg_q    <= WriteReg_In;
      end else if (done || timeout) begin
        ctrl_wb_q <= timeout ? {1'b0, fsm_wb[CTRL_WB_MEMTOREG]} : fsm_wb;
        rdata_q   <= (timeout || Mem_We) ? '0 : Mem_RData;
        alu_q     <= Mem_Addr;
        wreg_q    <= fsm_wreg;
      end
    end
  end

  assign Valid_Out     = valid_q;
  assign Ctrl_WBOut    = ctrl_wb_q;
  assign ReadData_Out  = rdata_q;
  assign ALU_ResultOut = alu_q;
  assign WriteReg_Out  = wreg_q;

endmodule

// File: tb/tb_mem_stage_unit.sv
// tb/tb_mem_stage_unit.sv - scoreboard bench for mem_stage_unit
// Covers the MEMSTAGE_TIMEOUT_EN build when that macro is defined.
module tb_mem_stage_unit;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Valid_In = 1'b0;
  logic [1:0]  Ctrl_WBIn = '0;
  logic [2:0]  Ctrl_MemIn = '0;
  logic [31:0] Adder_ResultIn = '0;
  logic [31:0] ALU_ResultIn = '0;
  logic        ALU_ZeroIn = 1'b0;
  logic [31:0] Register2_ReadIn = '0;
  logic [4:0]  WriteReg_In = '0;
  logic        Stall_Out, PCSrc_Out;
  logic [31:0] BranchTarget_Out;
  logic        Mem_Req, Mem_We;
  logic [31:0] Mem_Addr, Mem_WData;
  logic        Mem_Ack = 1'b0;
  logic [31:0] Mem_RData = '0;
  logic        Valid_Out;
  logic [1:0]  Ctrl_WBOut;
  logic [31:0] ReadData_Out, ALU_ResultOut;
  logic [4:0]  WriteReg_Out;
`ifdef MEMSTAGE_TIMEOUT_EN
  logic        Mem_Err_Out;
`endif

  always #5 Clk = ~Clk;

  mem_stage_unit #(
    .DATA_W(32)
`ifdef MEMSTAGE_TIMEOUT_EN
    , .TIMEOUT_CYC(4)
`endif
  ) dut (
    .Clk(Clk), .Rst(Rst), .Valid_In(Valid_In), .Ctrl_WBIn(Ctrl_WBIn),
    .Ctrl_MemIn(Ctrl_MemIn), .Adder_ResultIn(Adder_ResultIn),
    .ALU_ResultIn(ALU_ResultIn), .ALU_ZeroIn(ALU_ZeroIn),
    .Register2_ReadIn(Register2_ReadIn), .WriteReg_In(WriteReg_In),
    .Stall_Out(Stall_Out), .PCSrc_Out(PCSrc_Out),
    .BranchTarget_Out(BranchTarget_Out), .Mem_Req(Mem_Req), .Mem_We(Mem_We),
    .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData), .Mem_Ack(Mem_Ack),
    .Mem_RData(Mem_RData),
`ifdef MEMSTAGE_TIMEOUT_EN
    .Mem_Err_Out(Mem_Err_Out),
`endif
    .Valid_Out(Valid_Out), .Ctrl_WBOut(Ctrl_WBOut), .ReadData_Out(ReadData_Out),
    .ALU_ResultOut(ALU_ResultOut), .WriteReg_Out(WriteReg_Out)
  );

  typedef struct packed {
    logic [1:0]  wb;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wr;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_exp, mon_got;
  int   n_vec = 0;
  int   n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] wb, input logic [2:0] m, input logic [31:0] alu,
                       input logic [31:0] r2, input logic [31:0] adder, input logic z,
                       input logic [4:0] wr);
    Valid_In = 1'b1; Ctrl_WBIn = wb; Ctrl_MemIn = m; ALU_ResultIn = alu;
    Register2_ReadIn = r2; Adder_ResultIn = adder; ALU_ZeroIn = z; WriteReg_In = wr;
  endtask

  task automatic push(input logic [1:0] wb, input logic [31:0] rd, input logic [31:0] alu,
                      input logic [4:0] wr, input logic err);
    exp_t e;
    e.wb = wb; e.rd = rd; e.alu = alu; e.wr = wr; e.err = err;
    sb.push_back(e);
  endtask

  // Monitor: every retirement is matched against the oldest expected entry.
  always @(negedge Clk) begin
    if (Valid_Out === 1'b1) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_retire: Valid_Out=1 alu=0x%0h, expected no retirement", ALU_ResultOut);
      end else begin
        mon_exp = sb.pop_front();
        mon_got.wb = Ctrl_WBOut; mon_got.rd = ReadData_Out; mon_got.alu = ALU_ResultOut;
        mon_got.wr = WriteReg_Out;
`ifdef MEMSTAGE_TIMEOUT_EN
        mon_got.err = Mem_Err_Out;
`else
        mon_got.err = mon_exp.err;
`endif
        if (mon_got !== mon_exp) begin
          n_miss++;
          $display("FAIL retire: got wb=%b rd=0x%0h alu=0x%0h wr=%0d err=%b, expected wb=%b rd=0x%0h alu=0x%0h wr=%0d err=%b",
                   mon_got.wb, mon_got.rd, mon_got.alu, mon_got.wr, mon_got.err,
                   mon_exp.wb, mon_exp.rd, mon_exp.alu, mon_exp.wr, mon_exp.err);
        end
      end
    end
`ifdef MEMSTAGE_TIMEOUT_EN
    else if (Mem_Err_Out === 1'b1) begin
      n_vec++; n_miss++;
      $display("FAIL err_without_retire: Mem_Err_Out=1 with Valid_Out=0, expected 0");
    end
`endif
  end

  initial begin
    repeat (2) @(posedge Clk);
    #1;
    @(negedge Clk);
    chk("rst_valid", Valid_Out, 0);
    chk("rst_req", Mem_Req, 0);
    chk("rst_stall", Stall_Out, 0);
    chk("rst_wb", Ctrl_WBOut, 0);
    chk("rst_rdata", ReadData_Out, 0);
    tick(); Rst = 1'b0;

    // Two back-to-back ALU-only entries.
    drive(2'b10, 3'b000, 32'h1234, 0, 0, 0, 5'd8); push(2'b10, 0, 32'h1234, 5'd8, 0);
    @(negedge Clk);
    chk("alu_stall", Stall_Out, 0);
    chk("alu_pcsrc", PCSrc_Out, 0);
    tick();
    drive(2'b11, 3'b000, 32'h55, 0, 0, 0, 5'd9); push(2'b11, 0, 32'h55, 5'd9, 0);
    tick(); Valid_In = 1'b0;

    // Load at 0x40 acked at k=3.
    drive(2'b11, 3'b001, 32'h40, 0, 0, 0, 5'd3); push(2'b11, 32'hDEADBEEF, 32'h40, 5'd3, 0);
    tick(); Valid_In = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin Mem_Ack = 1'b1; Mem_RData = 32'hDEADBEEF; end
      @(negedge Clk);
      chk("ld_req", Mem_Req, 1);
      chk("ld_addr", Mem_Addr, 32'h40);
      chk("ld_stall", Stall_Out, 1);
      chk("ld_we", Mem_We, 0);
      tick();
    end
    Mem_Ack = 1'b0;
    @(negedge Clk);
    chk("ld_done_stall", Stall_Out, 0);
    chk("ld_done_req", Mem_Req, 0);

    // Store at 0x80 acked at k=1.
    tick();
    drive(2'b00, 3'b010, 32'h80, 32'hCAFE, 0, 0, 5'd0); push(2'b00, 0, 32'h80, 5'd0, 0);
    tick(); Valid_In = 1'b0; Mem_Ack = 1'b1; Mem_RData = 32'h11111111;
    @(negedge Clk);
    chk("st_we", Mem_We, 1);
    chk("st_wdata", Mem_WData, 32'hCAFE);
    chk("st_addr", Mem_Addr, 32'h80);
    tick(); Mem_Ack = 1'b0;
    @(negedge Clk);
    chk("st_done_req", Mem_Req, 0);

    // Illegal read+write: runs as a store with RegWrite cleared.
    tick();
    drive(2'b11, 3'b011, 32'h90, 32'h77, 0, 0, 5'd5); push(2'b01, 0, 32'h90, 5'd5, 0);
    tick(); Valid_In = 1'b0;
    @(negedge Clk);
    chk("ill_we", Mem_We, 1);
    chk("ill_wdata", Mem_WData, 32'h77);
    tick(); Mem_Ack = 1'b1; Mem_RData = 32'h2222;
    tick(); Mem_Ack = 1'b0;

    // Branch taken / not taken in IDLE.
    drive(2'b00, 3'b100, 32'h7, 0, 32'h200, 1, 5'd0); push(2'b00, 0, 32'h7, 5'd0, 0);
    @(negedge Clk);
    chk("br_pcsrc", PCSrc_Out, 1);
    chk("br_target", BranchTarget_Out, 32'h200);
    tick();
    drive(2'b00, 3'b100, 32'h8, 0, 32'h300, 0, 5'd0); push(2'b00, 0, 32'h8, 5'd0, 0);
    @(negedge Clk);
    chk("brnt_pcsrc", PCSrc_Out, 0);
    chk("brnt_target", BranchTarget_Out, 32'h300);
    tick();

    // Branch presented while a load is outstanding is held until IDLE.
    drive(2'b11, 3'b001, 32'h44, 0, 0, 0, 5'd4); push(2'b11, 32'h0BADF00D, 32'h44, 5'd4, 0);
    tick();
    drive(2'b00, 3'b100, 32'h7, 0, 32'h200, 1, 5'd0);
    @(negedge Clk);
    chk("brbusy_pcsrc", PCSrc_Out, 0);
    chk("brbusy_stall", Stall_Out, 1);
    tick(); Mem_Ack = 1'b1; Mem_RData = 32'h0BADF00D;
    push(2'b00, 0, 32'h7, 5'd0, 0);
    @(negedge Clk);
    chk("brbusy_pcsrc2", PCSrc_Out, 0);
    tick(); Mem_Ack = 1'b0;
    @(negedge Clk);
    chk("brheld_pcsrc", PCSrc_Out, 1);
    tick(); Valid_In = 1'b0;

    // Reset at k=2, late ack at k=3 must be ignored.
    drive(2'b11, 3'b001, 32'hA0, 0, 0, 0, 5'd6);
    tick(); Valid_In = 1'b0;
    tick(); Rst = 1'b1;
    tick(); Rst = 1'b0; Mem_Ack = 1'b1; Mem_RData = 32'h3333;
    @(negedge Clk);
    chk("rstbusy_req", Mem_Req, 0);
    chk("rstbusy_stall", Stall_Out, 0);
    tick(); Mem_Ack = 1'b0;
    @(negedge Clk);
    chk("rstbusy_req2", Mem_Req, 0);
    chk("rstbusy_valid", Valid_Out, 0);
    tick();
    drive(2'b10, 3'b000, 32'h99, 0, 0, 0, 5'd7); push(2'b10, 0, 32'h99, 5'd7, 0);
    tick(); Valid_In = 1'b0;

`ifdef MEMSTAGE_TIMEOUT_EN
    begin
      int n;
      n = 0;
      drive(2'b11, 3'b001, 32'hB0, 0, 0, 0, 5'd2); push(2'b01, 0, 32'hB0, 5'd2, 1);
      tick(); Valid_In = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge Clk);
        if (!Stall_Out) break;
        n++;
      end
      chk("to_busy_cycles", n, 4);
    end
`endif

    repeat (3) tick();
    chk("sb_drain", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
